// File: rtl/muldiv_if.sv
// Request/result bundle for muldiv_unit.
//   master : execute-stage issuer (drives request, flush and out_ready)
//   slave  : the multiply/divide unit
// Signals
//   flush              abort the operation in flight (synchronous)
//   in_valid/in_ready  request handshake; op, word, a, b qualify it
//   out_valid/out_ready result handshake; result qualifies it
//   busy               unit is not idle
interface muldiv_if #(
  parameter int XLEN = 64,
  parameter int OPW  = 3
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [OPW-1:0]  op;
  logic            word;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output flush, in_valid, op, word, a, b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  flush, in_valid, op, word, a, b, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
// plus W forms). One shift-add or restoring-divide step per cycle over N bits,
// N = 32 for W ops, XLEN otherwise.
// Ports
//   clk   clock
//   rst   asynchronous, active-high reset
//   bus   muldiv_if.slave: request/result handshakes, flush, busy
// Build option
//   MULDIV_EARLY_OUT_EN : trivial divides (b==0, MIN/-1, |a|<|b|) and multiplies
//                         by zero finish one cycle after acceptance.
// Timing: a request accepted at edge T spends one cycle preparing, then N step
// cycles, so out_valid rises after edge T+N+1.
module muldiv_unit #(
  parameter int XLEN = 64,
  parameter int OPW  = 3
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic              word_q, word_d;
  logic              prep_q, prep_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]   quo_q, quo_d, rem_q, rem_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  function automatic logic [XLEN-1:0] fit_word(input logic [XLEN-1:0] v, input logic uw);
    return uw ? XLEN'($signed(v[31:0])) : v;
  endfunction

  // Operand preparation: word truncation/extension, signs and magnitudes.
  // a_q/b_q stay stable for the whole operation, so these are static per op.
  logic            use_word, is_div, a_signed, b_signed, sa, sb;
  logic [XLEN-1:0] a_x, b_x, ma, mb;

  assign use_word = (XLEN == 64) && word_q;
  assign is_div   = op_q[2];

  always_comb begin
    a_signed = op_q inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_signed = op_q inside {OP_MULH, OP_DIV, OP_REM};
    if (use_word) begin
      a_x = a_signed ? XLEN'($signed(a_q[31:0])) : XLEN'(a_q[31:0]);
      b_x = b_signed ? XLEN'($signed(b_q[31:0])) : XLEN'(b_q[31:0]);
    end else begin
      a_x = a_q;
      b_x = b_q;
    end
    sa = a_signed & a_x[XLEN-1];
    sb = b_signed & b_x[XLEN-1];
    ma = sa ? -a_x : a_x;
    mb = sb ? -b_x : b_x;
  end

  // One iteration, MSB first, for both datapaths, plus the sign fix-up of the
  // value that iteration would produce (only registered on the last step).
  logic [2*XLEN-1:0] prod_step, prod_fix;
  logic [XLEN:0]     rem_sh;
  logic              ge;
  logic [XLEN-1:0]   rem_step, quo_step, rem_fix, quo_fix, raw_res;

  always_comb begin
    prod_step = (prod_q << 1) + (ma[cnt_q] ? (2*XLEN)'(mb) : '0);
    rem_sh    = {rem_q, ma[cnt_q]};
    ge        = rem_sh >= {1'b0, mb};
    rem_step  = ge ? XLEN'(rem_sh - {1'b0, mb}) : XLEN'(rem_sh);
    quo_step  = {quo_q[XLEN-2:0], ge};

    prod_fix = (sa ^ sb) ? -prod_step : prod_step;
    quo_fix  = (sa ^ sb) ? -quo_step  : quo_step;
    rem_fix  = sa ? -rem_step : rem_step;

    if (is_div) begin
      // Divide by zero bypasses the datapath so the sign fix-up cannot touch it.
      if (b_x == '0) raw_res = op_q[1] ? a_x : '1;
      else           raw_res = op_q[1] ? rem_fix : quo_fix;
    end else if (op_q == OP_MUL) begin
      raw_res = prod_fix[XLEN-1:0];
    end else if (use_word) begin
      raw_res = prod_fix[32 +: XLEN];
    end else begin
      raw_res = prod_fix[XLEN +: XLEN];
    end
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic            early_hit, ovf;
  logic [XLEN-1:0] early_raw, min_x;

  always_comb begin
    min_x     = use_word ? XLEN'($signed(32'h8000_0000)) : {1'b1, {(XLEN-1){1'b0}}};
    ovf       = b_signed && (b_x == '1) && (a_x == min_x);
    early_hit = 1'b0;
    early_raw = '0;
    if (is_div) begin
      if (b_x == '0) begin
        early_hit = 1'b1;
        early_raw = op_q[1] ? a_x : '1;
      end else if (ovf) begin
        early_hit = 1'b1;
        early_raw = op_q[1] ? '0 : a_x;
      end else if (ma < mb) begin
        early_hit = 1'b1;
        early_raw = op_q[1] ? a_x : '0;
      end
    end else if (a_x == '0 || b_x == '0) begin
      early_hit = 1'b1;
    end
  end
`endif

  // NOTE: every combinational output is given a default first, so no path
  // through the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    word_d   = word_q;
    prep_d   = prep_q;
    a_d      = a_q;
    b_d      = b_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        // flush wins over a same-cycle request.
        if (bus.in_valid && !bus.flush) begin
          op_d    = op_e'(bus.op[2:0]);
          word_d  = bus.word;
          a_d     = bus.a;
          b_d     = bus.b;
          prep_d  = 1'b1;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else if (prep_q) begin
          prep_d = 1'b0;
          prod_d = '0;
          rem_d  = '0;
          quo_d  = '0;
          cnt_d  = use_word ? CW'(31) : CW'(XLEN - 1);
`ifdef MULDIV_EARLY_OUT_EN
          if (early_hit) begin
            result_d = fit_word(early_raw, use_word);
            state_d  = S_DONE;
          end
`endif
        end else begin
          prod_d = prod_step;
          rem_d  = rem_step;
          quo_d  = quo_step;
          if (cnt_q == '0) begin
            result_d = fit_word(raw_res, use_word);
            state_d  = S_DONE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      S_DONE: begin
        if (bus.flush || bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MUL;
      word_q   <= 1'b0;
      prep_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      word_q   <= word_d;
      prep_q   <= prep_d;
      a_q      <= a_d;
      b_q      <= b_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE) && !rst;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.result    = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  localparam int XLEN = 64;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic [2:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    bit          early;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  muldiv_if #(.XLEN(XLEN), .OPW(3)) bus ();
  muldiv_unit #(.XLEN(XLEN), .OPW(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    bus.op = op; bus.word = w; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_vectors(input vec_t v[], input string tag);
    int lat, exp_lat;
    logic [63:0] res;
    for (int i = 0; i < v.size(); i++) begin
      issue(v[i].op, v[i].w, v[i].a, v[i].b);
      wait_valid(lat);
      res = bus.result;
      exp_lat = (EARLY && v[i].early) ? 1 : (v[i].w ? 33 : 65);
      checks++;
      if (res !== v[i].exp) begin
        errors++;
        $display("FAIL %s[%0d] op=%0d result got %h want %h", tag, i, v[i].op, res, v[i].exp);
      end
      checks++;
      if (lat !== exp_lat) begin
        errors++;
        $display("FAIL %s[%0d] op=%0d latency got %0d want %0d", tag, i, v[i].op, lat, exp_lat);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.flush = 0; bus.in_valid = 0; bus.op = 0; bus.word = 0;
    bus.a = 0; bus.b = 0; bus.out_ready = 1;
    #12;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.result !== 64'd0) begin errors++; $display("FAIL reset_result got %h want 0", bus.result); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_mul();
    vec_t v[] = new[6];
    v[0] = '{3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0};
    v[1] = '{3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    v[2] = '{3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0};
    v[3] = '{3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    v[4] = '{3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    v[5] = '{3'd0, 1'b0, 64'd0, 64'd5, 64'd0, 1'b1};
    run_vectors(v, "mul");
  endtask

  task automatic test_div();
    vec_t v[] = new[10];
    v[0] = '{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
    v[1] = '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    v[2] = '{3'd5, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    v[3] = '{3'd7, 1'b0, 64'd5, 64'd0, 64'd5, 1'b1};
    v[4] = '{3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1};
    v[5] = '{3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1};
    v[6] = '{3'd5, 1'b0, 64'd3, 64'd10, 64'd0, 1'b1};
    v[7] = '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd10, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1};
    v[8] = '{3'd4, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0};
    v[9] = '{3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 1'b0};
    run_vectors(v, "div");
  endtask

  task automatic test_word();
    vec_t v[] = new[4];
    v[0] = '{3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1'b1};
    v[1] = '{3'd5, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    v[2] = '{3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    v[3] = '{3'd7, 1'b1, 64'hFFFF_FFFF_8000_0001, 64'h1234_5678_0000_0000, 64'hFFFF_FFFF_8000_0001, 1'b1};
    run_vectors(v, "word");
  endtask

  task automatic test_flush();
    bit seen = 1'b0;
    int lat;
    issue(3'd4, 1'b0, 64'd100, 64'd3);
    // prep at T+1 loads cnt=63; cnt reaches 10 after edge T+54
    for (int i = 0; i < 54; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", bus.busy); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b want 1", bus.in_ready); end
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_valid got %b want 0", seen); end
    issue(3'd0, 1'b0, 64'd3, 64'd4);
    wait_valid(lat);
    checks++; if (bus.result !== 64'd12) begin errors++; $display("FAIL flush_next_mul got %h want %h", bus.result, 64'd12); end
    checks++; if (lat !== 65) begin errors++; $display("FAIL flush_next_lat got %0d want 65", lat); end
    @(posedge clk); #1;
    // flush and a request in the same cycle: the request must be dropped
    bus.flush = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_vs_req busy got %b want 0", bus.busy); end
  endtask

  task automatic test_backpressure();
    int lat;
    bit bad = 1'b0;
    bus.out_ready = 1'b0;
    issue(3'd5, 1'b0, 64'd100, 64'd7);
    wait_valid(lat);
    checks++; if (bus.result !== 64'd14) begin errors++; $display("FAIL bp_result got %h want %h", bus.result, 64'd14); end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.result !== 64'd14 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL bp_stall_stable got %b want 0", bad); end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_async_reset();
    issue(3'd0, 1'b0, 64'd7, 64'd3);
    repeat (10) @(posedge clk);
    #3;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL arst_pre_busy got %b want 1", bus.busy); end
    rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b want 0", bus.busy); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid got %b want 0", bus.out_valid); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_word();
    test_flush();
    test_backpressure();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
